// File: rtl/inet_checksum_stream.sv
// Streaming RFC 1071 ones-complement checksum over a big-endian byte stream, DATA_W of 8/16/32.
// Define CHKSUM_VERIFY_EN to add the m_ok output (received checksum verifies to zero).
module inet_checksum_stream #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic              s_last,
  input  logic [15:0]       init_sum,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       m_checksum,
  output logic              busy
`ifdef CHKSUM_VERIFY_EN
  ,
  output logic              m_ok
`endif
);

  localparam int LANES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCUM, FOLD, OUT} state_t;

  state_t              state, state_nxt;
  logic [31:0]         acc;
  logic                parity;
  logic                fold_cnt;
  logic                accept;
  logic [LANES-1:0]    eff_keep;
  logic [17:0]         beat_words;

  // Expand the per-lane keep bits into a byte mask; keep[LANES-1] is the first byte on the wire.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] keep);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  // Sum of the 16-bit words carried by one beat; a byte-wide beat lands in the high or low half by position.
  function automatic logic [17:0] beat_sum(input logic [DATA_W-1:0] data, input logic odd);
    logic [31:0] x;
    logic [17:0] s;
    x = '0;
    x[DATA_W-1:0] = data;
    if (DATA_W == 8)
      s = odd ? {10'b0, x[7:0]} : {2'b0, x[7:0], 8'b0};
    else
      s = 18'(x[31:16]) + 18'(x[15:0]);
    return s;
  endfunction

  assign s_ready    = !rst && (state == IDLE || state == ACCUM);
  assign accept     = s_valid && s_ready;
  assign m_valid    = !rst && (state == OUT);
  assign m_checksum = m_valid ? ~acc[15:0] : 16'h0000;
  assign busy       = !rst && ((state != IDLE) || accept);
`ifdef CHKSUM_VERIFY_EN
  assign m_ok       = m_valid && (acc[15:0] == 16'hFFFF);
`endif

  assign eff_keep   = s_last ? s_keep : {LANES{1'b1}};
  assign beat_words = beat_sum(s_data & lane_mask(eff_keep), (state == ACCUM) && parity);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = s_last ? FOLD : ACCUM;
      FOLD:        if (fold_cnt) state_nxt = OUT;
      OUT:         if (m_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Accumulation is unfolded; two end-around folds bring any 65535-byte sum into 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      parity   <= 1'b0;
      fold_cnt <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          acc      <= 32'(init_sum) + 32'(beat_words);
          parity   <= 1'b1;
          fold_cnt <= 1'b0;
        end
        ACCUM: if (accept) begin
          acc    <= acc + 32'(beat_words);
          parity <= ~parity;
        end
        FOLD: begin
          acc      <= 32'(acc[31:16]) + 32'(acc[15:0]);
          fold_cnt <= 1'b1;
        end
        OUT: if (m_ready) begin
          parity   <= 1'b0;
          fold_cnt <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/inet_checksum_stream.md
INET_CHECKSUM_STREAM -- requirements
Module: inet_checksum_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the beat width in bits; legal values are 8, 16 and 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have port s_valid, input, 1 bit: an input beat is present.
REQ-005 SHALL have port s_ready, output, 1 bit: the block can accept a beat.
REQ-006 SHALL have port s_data, input, DATA_W bits: packet bytes, big-endian; the first byte on the wire is s_data[DATA_W-1:DATA_W-8].
REQ-007 SHALL have port s_keep, input, DATA_W/8 bits: byte-lane valid mask, MSB lane first, contiguous, consulted on the last beat only.
REQ-008 SHALL have port s_last, input, 1 bit: the beat is the final beat of the packet.
REQ-009 SHALL have port init_sum, input, 16 bits: preload value (for example a pseudo-header sum), sampled with the first beat.
REQ-010 SHALL have port m_valid, output, 1 bit: a checksum result is available.
REQ-011 SHALL have port m_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port m_checksum, output, 16 bits: the ones-complement checksum result.
REQ-013 SHALL have port busy, output, 1 bit: high from the first accepted beat until the result is accepted.

Function
REQ-014 SHALL implement a four-state machine with states IDLE, ACCUM, FOLD and OUT.
REQ-015 SHALL accept a beat only when s_valid and s_ready are both high; s_ready is high in IDLE and ACCUM, and low in FOLD, OUT and while rst is high.
REQ-016 SHALL load a 32-bit accumulator with init_sum plus the first beat's words, on the beat accepted in IDLE.
REQ-017 SHALL add each later beat's 16-bit words to the accumulator, with no folding during accumulation.
REQ-018 SHALL, when DATA_W is 8, track byte parity: even-position bytes go to bits [15:8] and odd-position bytes go to bits [7:0].
REQ-019 SHALL, on the last beat, treat lanes with s_keep=0 as zero; an odd final byte is padded with a zero low byte.
REQ-020 SHALL treat s_keep as all-ones on non-last beats, whatever its actual value.
REQ-021 SHALL move IDLE->ACCUM on an accepted first beat with s_last=0.
REQ-022 SHALL move IDLE->FOLD or ACCUM->FOLD on an accepted beat with s_last=1; a single-beat packet is legal.
REQ-023 SHALL spend exactly 2 cycles in FOLD, each cycle setting acc <= acc[31:16] + acc[15:0].
REQ-024 SHALL then enter OUT with m_checksum = ~acc[15:0].
REQ-025 SHALL raise m_valid exactly 2 cycles after the clock edge that accepts the last beat.
REQ-026 SHALL hold m_valid and m_checksum stable until m_valid and m_ready are both high; it then returns to IDLE, with s_ready high the next cycle.
REQ-027 SHALL output a result of 0x0000 unchanged, with no 0xFFFF substitution.
REQ-028 SHALL produce correct results for packets up to 65535 bytes, which cannot overflow the 32-bit accumulator.
REQ-029 SHALL assert busy in ACCUM, FOLD and OUT, and also on the IDLE cycle that accepts a beat.

Reset
REQ-030 SHALL, while rst is high, set the state to IDLE and clear the accumulator and the byte-parity tracker.
REQ-031 SHALL, while rst is high, drive m_valid=0, m_checksum=16'h0000, busy=0 and s_ready=0.
REQ-032 SHALL, when rst is asserted mid-packet or mid-output, discard the partial result; the next accepted beat starts a fresh packet.

Configuration
REQ-033 SHALL, with macro CHKSUM_VERIFY_EN defined, add output m_ok (1 bit), valid with m_valid, high when the folded sum is 16'hFFFF (that is, m_checksum==0); m_ok resets to 0.
REQ-034 SHALL, without CHKSUM_VERIFY_EN, omit the m_ok port and its logic; all other behaviour is identical.

Verification
REQ-035 SHALL cover the DATA_W=16 IPv4 header case: beats 4500 0073 0000 4000 4011 0000 c0a8 0001 c0a8 00c7 with init_sum 0 -> m_checksum 16'hB861, with m_valid 2 cycles after the last beat.
REQ-036 SHALL cover the same header with 0000 replaced by b861 -> m_checksum 16'h0000, and m_ok=1 when CHKSUM_VERIFY_EN is defined.
REQ-037 SHALL cover odd lengths:
- DATA_W=8, bytes 01 02 03 -> 16'hFBFD.
- DATA_W=32, single last beat 01020300 with s_keep 4'b1110 -> 16'hFBFD.
REQ-038 SHALL cover double fold: init_sum FFFF, beats FFFF then 0001 -> m_checksum 16'hFFFE.
REQ-039 SHALL cover backpressure: m_ready held low 5 cycles -> m_valid and m_checksum stable, s_ready=0, and no s_valid beat accepted.
REQ-040 SHALL cover reset mid-packet: rst pulsed after 3 beats -> outputs at reset values; the REQ-035 packet sent afterwards -> 16'hB861.
